// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID elastic pipeline register.
// Holds the control state encoding, the NOP instruction word and default widths.
package if_id_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int DEFAULT_PC_W    = 32;
    localparam int DEFAULT_INSTR_W = 32;
    localparam int DEFAULT_LANES   = 1;

    // Wide enough for any supported instruction width; users slice the low bits.
    localparam logic [63:0] NOP_INSTR = 64'd0;

endpackage

// File: rtl/if_id_entry.sv
// One fetch-bundle payload register (PC, lane instructions, lane mask).
// Lanes whose mask bit is clear are stored as NOP so decode never sees stale words.
module if_id_entry
    import if_id_pkg::*;
#(
    parameter int PC_W    = DEFAULT_PC_W,
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int LANES   = DEFAULT_LANES
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic                     clear_i,
    input  logic [PC_W-1:0]          pc_i,
    input  logic [LANES*INSTR_W-1:0] instr_i,
    input  logic [LANES-1:0]         mask_i,
    output logic [PC_W-1:0]          pc_o,
    output logic [LANES*INSTR_W-1:0] instr_o,
    output logic [LANES-1:0]         mask_o
);

    logic [PC_W-1:0]          pc_q;
    logic [LANES*INSTR_W-1:0] instr_q;
    logic [LANES*INSTR_W-1:0] instrScrubbed;
    logic [LANES-1:0]         mask_q;

    always_comb begin
        instrScrubbed = '0;
        for (int i = 0; i < LANES; i++) begin
            instrScrubbed[i*INSTR_W +: INSTR_W] = mask_i[i] ? instr_i[i*INSTR_W +: INSTR_W]
                                                            : NOP_INSTR[INSTR_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            pc_q    <= '0;
            instr_q <= '0;
            mask_q  <= '0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instrScrubbed;
            mask_q  <= mask_i;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign mask_o  = mask_q;

endmodule

// File: rtl/if_id_skid_register.sv
// Elastic IF/ID register with a two-entry skid buffer so In_Ready comes from a flop.
// MAIN drives the decode-side outputs directly; SKID catches the bundle accepted while stalled.
module if_id_skid_register
    import if_id_pkg::*;
#(
    parameter int PC_W    = DEFAULT_PC_W,
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int LANES   = DEFAULT_LANES
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [PC_W-1:0]          In_PC,
    input  logic [LANES*INSTR_W-1:0] In_Instr,
    input  logic [LANES-1:0]         In_LaneMask,
    input  logic                     Flush,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [PC_W-1:0]          Out_PC,
    output logic [LANES*INSTR_W-1:0] Out_Instr,
    output logic [LANES-1:0]         Out_LaneMask,
    output logic [1:0]               Occupancy
);

    state_e state_q, state_d;
    logic   inReady_q;
    logic   inFire, outFire;
    logic   mainLoad, skidLoad, mainFromSkid;

    logic [PC_W-1:0]          skidPc, mainPcIn;
    logic [LANES*INSTR_W-1:0] skidInstr, mainInstrIn;
    logic [LANES-1:0]         skidMask, mainMaskIn;

    assign In_Ready = inReady_q;
    assign inFire   = In_Valid & inReady_q;
    assign outFire  = Out_Valid & Out_Ready;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= EMPTY;
            inReady_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            inReady_q <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (inFire) state_d = ONE;
            ONE: begin
                if (inFire && !outFire)      state_d = TWO;
                else if (!inFire && outFire) state_d = EMPTY;
            end
            TWO:     if (outFire) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (Flush) state_d = EMPTY;
    end

    // Flush suppresses every load; both entries are cleared by the shared clear input.
    always_comb begin
        Out_Valid    = (state_q != EMPTY);
        Occupancy    = state_q;
        mainLoad     = 1'b0;
        skidLoad     = 1'b0;
        mainFromSkid = (state_q == TWO);
        if (!Flush) begin
            case (state_q)
                EMPTY: mainLoad = inFire;
                ONE: begin
                    mainLoad = inFire & outFire;
                    skidLoad = inFire & ~outFire;
                end
                TWO:     mainLoad = outFire;
                default: mainLoad = 1'b0;
            endcase
        end
    end

    assign mainPcIn    = mainFromSkid ? skidPc    : In_PC;
    assign mainInstrIn = mainFromSkid ? skidInstr : In_Instr;
    assign mainMaskIn  = mainFromSkid ? skidMask  : In_LaneMask;

    if_id_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LANES(LANES)) uMain (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .load_i  (mainLoad),
        .clear_i (Flush),
        .pc_i    (mainPcIn),
        .instr_i (mainInstrIn),
        .mask_i  (mainMaskIn),
        .pc_o    (Out_PC),
        .instr_o (Out_Instr),
        .mask_o  (Out_LaneMask)
    );

    if_id_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LANES(LANES)) uSkid (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .load_i  (skidLoad),
        .clear_i (Flush),
        .pc_i    (In_PC),
        .instr_i (In_Instr),
        .mask_i  (In_LaneMask),
        .pc_o    (skidPc),
        .instr_o (skidInstr),
        .mask_o  (skidMask)
    );

endmodule

// File: tb/tb_if_id_skid_register.sv
// Bench for if_id_skid_register (4 lanes): a queue model of the buffer checked every cycle,
// directed vectors with literal expectations, and a random Out_Ready phase with an in-order log check.
module tb_if_id_skid_register;

    logic         Clk, Rst_n, In_Valid, In_Ready, Flush, Out_Valid, Out_Ready;
    logic [31:0]  In_PC, Out_PC;
    logic [127:0] In_Instr, Out_Instr;
    logic [3:0]   In_LaneMask, Out_LaneMask;
    logic [1:0]   Occupancy;

    if_id_skid_register #(.PC_W(32), .INSTR_W(32), .LANES(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_PC(In_PC), .In_Instr(In_Instr), .In_LaneMask(In_LaneMask), .Flush(Flush),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_PC(Out_PC),
        .Out_Instr(Out_Instr), .Out_LaneMask(Out_LaneMask), .Occupancy(Occupancy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] instr;
        logic [3:0]   mask;
    } bundle_t;

    int      checks = 0;
    int      errors = 0;
    bundle_t modelQ[$];
    bundle_t shown;
    logic    modelReady = 1'b1;
    logic    modelLive = 1'b0;
    logic    lastInFire = 1'b0;
    logic [31:0] dutLog[$];

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] scrub(input logic [127:0] instr, input logic [3:0] mask);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (mask[i]) r[i*32 +: 32] = instr[i*32 +: 32];
        return r;
    endfunction

    // Model: the buffer is a FIFO of at most two bundles; the head is what decode sees.
    always @(posedge Clk) begin
        logic inFire, outFire;
        bundle_t b;
        inFire  = In_Valid && modelReady;
        outFire = (modelQ.size() > 0) && Out_Ready;
        lastInFire = 1'b0;
        if (!Rst_n || Flush) begin
            modelQ.delete();
            shown = '{32'd0, 128'd0, 4'd0};
            modelReady = 1'b1;
            if (!Rst_n) modelLive = 1'b1;
        end else begin
            if (outFire) void'(modelQ.pop_front());
            if (inFire) begin
                b = '{In_PC, scrub(In_Instr, In_LaneMask), In_LaneMask};
                modelQ.push_back(b);
                lastInFire = 1'b1;
            end
            modelReady = (modelQ.size() < 2);
            if (modelQ.size() > 0) shown = modelQ[0];
        end
    end

    always @(posedge Clk) begin
        if (Rst_n === 1'b1 && Out_Valid === 1'b1 && Out_Ready === 1'b1) dutLog.push_back(Out_PC);
    end

    always @(negedge Clk) begin
        if (modelLive) begin
            checkOutput("cyc_outValid", 128'(Out_Valid), 128'(modelQ.size() > 0));
            checkOutput("cyc_occupancy", 128'(Occupancy), 128'(modelQ.size()));
            checkOutput("cyc_inReady", 128'(In_Ready), 128'(modelReady));
            checkOutput("cyc_outPc", 128'(Out_PC), 128'(shown.pc));
            checkOutput("cyc_outInstr", Out_Instr, shown.instr);
            checkOutput("cyc_outMask", 128'(Out_LaneMask), 128'(shown.mask));
        end
    end

    task automatic applyStimulus(input logic rstn, input logic flush, input logic valid,
                                 input logic [31:0] pc, input logic [127:0] instr,
                                 input logic [3:0] mask, input logic outRdy);
        Rst_n = rstn; Flush = flush; In_Valid = valid; In_PC = pc;
        In_Instr = instr; In_LaneMask = mask; Out_Ready = outRdy;
        @(posedge Clk);
        #1;
    endtask

    localparam logic [127:0] FILL = {3{32'hDEADBEEF}} << 32;
    localparam logic [127:0] ONES = {4{32'hFFFFFFFF}};

    initial begin
        logic [31:0] expLog[$];
        logic [31:0] nextPc;
        int accepted;
        Rst_n = 1'b0; Flush = 1'b0; In_Valid = 1'b1; In_PC = 32'h55;
        In_Instr = ONES; In_LaneMask = 4'hF; Out_Ready = 1'b0;

        applyStimulus(0, 0, 1, 32'h55, ONES, 4'hF, 0);
        applyStimulus(0, 0, 1, 32'h55, ONES, 4'hF, 0);
        checkOutput("rst_outValid", 128'(Out_Valid), 128'd0);
        checkOutput("rst_occupancy", 128'(Occupancy), 128'd0);
        checkOutput("rst_outInstr", Out_Instr, 128'd0);
        checkOutput("rst_inReady", 128'(In_Ready), 128'd1);

        applyStimulus(1, 0, 1, 32'h100, FILL | 128'h20080005, 4'b0001, 0);
        checkOutput("first_outValid", 128'(Out_Valid), 128'd1);
        checkOutput("first_outPc", 128'(Out_PC), 128'h100);
        checkOutput("first_outInstr", Out_Instr, 128'h20080005);
        applyStimulus(1, 0, 0, 32'h0, 128'd0, 4'h0, 1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 1, 32'(i * 4), {4{32'(i * 4 + 1)}}, 4'hF, 1);
            checkOutput("stream_outPc", 128'(Out_PC), 128'(i * 4));
            checkOutput("stream_occupancy", 128'(Occupancy), 128'd1);
        end
        applyStimulus(1, 0, 0, 32'h0, 128'd0, 4'h0, 1);

        applyStimulus(1, 0, 1, 32'h10, ONES, 4'hF, 0);
        applyStimulus(1, 0, 1, 32'h14, ONES, 4'hF, 0);
        checkOutput("bp_occupancy", 128'(Occupancy), 128'd2);
        checkOutput("bp_inReady", 128'(In_Ready), 128'd0);
        checkOutput("bp_outPc", 128'(Out_PC), 128'h10);
        applyStimulus(1, 0, 1, 32'h99, ONES, 4'hF, 0);
        checkOutput("bp_hold_outPc", 128'(Out_PC), 128'h10);
        applyStimulus(1, 0, 0, 32'h0, 128'd0, 4'h0, 1);
        checkOutput("bp_release_outPc", 128'(Out_PC), 128'h14);
        checkOutput("bp_release_occupancy", 128'(Occupancy), 128'd1);

        applyStimulus(1, 0, 1, 32'h1C, ONES, 4'hF, 1);
        applyStimulus(1, 0, 1, 32'h20, ONES, 4'hF, 0);
        checkOutput("two_occupancy", 128'(Occupancy), 128'd2);
        applyStimulus(1, 1, 1, 32'h18, ONES, 4'hF, 1);
        checkOutput("flush_occupancy", 128'(Occupancy), 128'd0);
        checkOutput("flush_outValid", 128'(Out_Valid), 128'd0);
        checkOutput("flush_outInstr", Out_Instr, 128'd0);
        checkOutput("flush_inReady", 128'(In_Ready), 128'd1);

        applyStimulus(1, 0, 1, 32'h24, ONES, 4'b0101, 0);
        checkOutput("scrub_outInstr", Out_Instr, {32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF});
        checkOutput("scrub_outMask", 128'(Out_LaneMask), 128'b0101);
        applyStimulus(1, 0, 1, 32'h30, ONES, 4'b0000, 1);
        checkOutput("bubble_outValid", 128'(Out_Valid), 128'd1);
        checkOutput("bubble_outPc", 128'(Out_PC), 128'h30);
        checkOutput("bubble_outInstr", Out_Instr, 128'd0);

        applyStimulus(0, 1, 1, 32'h40, ONES, 4'hF, 0);
        checkOutput("rstflush_outValid", 128'(Out_Valid), 128'd0);
        checkOutput("rstflush_outPc", 128'(Out_PC), 128'd0);
        checkOutput("rstflush_inReady", 128'(In_Ready), 128'd1);
        checkOutput("rstflush_occupancy", 128'(Occupancy), 128'd0);

        nextPc = 32'h1000;
        accepted = 0;
        for (int c = 0; c < 300; c++) begin
            applyStimulus(1, 0, 1'($urandom_range(0, 1)), nextPc,
                          {nextPc + 32'd3, nextPc + 32'd2, nextPc + 32'd1, nextPc},
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            if (lastInFire) begin
                nextPc += 32'd4;
                accepted++;
            end
        end
        for (int c = 0; c < 4; c++) applyStimulus(1, 0, 0, 32'h0, 128'd0, 4'h0, 1);

        expLog = '{32'h100, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h1C, 32'h24};
        for (int k = 0; k < accepted; k++) expLog.push_back(32'h1000 + 32'(k * 4));
        checkOutput("log_length", 128'(dutLog.size()), 128'(expLog.size()));
        for (int k = 0; k < expLog.size() && k < dutLog.size(); k++)
            checkOutput("log_pc", 128'(dutLog[k]), 128'(expLog[k]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_skid_register.md
Name: if_id_skid_register

Overview:
- Parametrised, elastic IF/ID pipeline register with valid/ready handshakes on both sides.
- Carries a fetch bundle (PC plus LANES instructions with a per-lane valid mask) from fetch to decode.
- A two-entry skid buffer lets In_Ready be driven from a flop, so the backpressure path is fully registered.
- Flush kills everything in flight. Instruction word zero is the NOP encoding.

Parameters:
PC_W, 32, program-counter width
INSTR_W, 32, width of one instruction
LANES, 1, instructions per fetch bundle (1..8)

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  synchronous active-low reset
In_Valid  in  1  fetch presents a bundle
In_Ready  out  1  register can accept a bundle; driven directly from a flop
In_PC  in  PC_W  PC of lane 0
In_Instr  in  LANES*INSTR_W  instructions; lane i at bits [i*INSTR_W +: INSTR_W]
In_LaneMask  in  LANES  per-lane valid bits
Flush  in  1  discard all held and incoming bundles
Out_Valid  out  1  decode-side bundle valid
Out_Ready  in  1  decode accepts the bundle
Out_PC  out  PC_W  held PC
Out_Instr  out  LANES*INSTR_W  held instructions
Out_LaneMask  out  LANES  held lane mask
Occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Reset and clocking:
  - One clock, Clk.
  - Reset is synchronous and active-low on Rst_n; it is sampled only at the Clk rising edge.
- Reset values:
  - State is EMPTY, Out_Valid=0, In_Ready=1, Occupancy=0.
  - Out_PC, Out_Instr, Out_LaneMask are all 0, and both entries' payloads are 0.
- Handshake terms:
  - in_fire = In_Valid & In_Ready.
  - out_fire = Out_Valid & Out_Ready.
- Entries and outputs:
  - Two entries: MAIN drives the outputs; SKID holds overflow.
  - Out_* are MAIN's registers directly; there is no combinational path from In_* to Out_*.
- Latency: a bundle accepted on cycle N appears with Out_Valid=1 on cycle N+1.
- Lane scrub on write: any lane whose mask bit is 0 is stored as instruction 0 (NOP).
- State machine, EMPTY (MAIN and SKID empty):
  - in_fire -> ONE, MAIN<=in.
- State machine, ONE (MAIN full):
  - in_fire & out_fire -> ONE, MAIN<=in.
  - in_fire & !out_fire -> TWO, SKID<=in.
  - !in_fire & out_fire -> EMPTY.
  - Neither fires -> hold.
- State machine, TWO (MAIN and SKID full):
  - In_Ready=0, so no in_fire is possible.
  - out_fire -> ONE, MAIN<=SKID.
  - Otherwise hold.
- Derived outputs:
  - In_Ready is registered and equals (next state != TWO).
  - Out_Valid = (state != EMPTY).
  - Occupancy = 0/1/2 for EMPTY/ONE/TWO.
- Stability: while Out_Valid & !Out_Ready, Out_PC, Out_Instr and Out_LaneMask are held bit-stable. PC and instructions always move together, never independently.
- Flush:
  - Next state is EMPTY, and any same-cycle in_fire is discarded.
  - MAIN payload is cleared to 0; SKID is invalidated.
  - In_Ready=1 on the following cycle.
  - Flush overrides in_fire and out_fire. The out_fire of the current MAIN still counts as consumed by decode in that cycle.
- Priority: Rst_n low > Flush > normal transfers.
- All-zero In_LaneMask with In_Valid=1: accepted and forwarded as a bubble bundle; it is not dropped.
- Reset mid-operation: both entries are lost and there are no partial transfers; reset values apply on the next edge.
- Out_Ready is allowed to toggle every cycle; the buffer sustains 1 bundle/cycle throughput when Out_Ready=1.

Decomposition:
- Shared package if_id_pkg:
  - State enum: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - NOP_INSTR = 0.
  - Default PC_W/INSTR_W/LANES constants.
- Sub-module if_id_entry: one payload register (PC, instructions, mask) with load-enable, synchronous clear and lane scrub. It is instantiated twice, for MAIN and SKID.
- Control FSM stays in the top module.

Test Plan:
- Reset: hold Rst_n=0 for 2 cycles with In_Valid=1 -> Out_Valid=0, Occupancy=0, Out_Instr=0, In_Ready=1. Release; In_PC=0x100, In_Instr=0x20080005 -> next cycle Out_Valid=1, Out_PC=0x100, Out_Instr=0x20080005.
- Streaming: Out_Ready=1, in_fire every cycle with PCs 0x0,0x4,0x8,0xC -> outputs the same sequence on consecutive cycles, Occupancy stays 1, no gaps.
- Backpressure: Out_Ready=0 and push 0x10, 0x14 -> Occupancy=2, In_Ready=0, Out_PC stable at 0x10 throughout. Raise Out_Ready -> 0x10 then 0x14 delivered, no loss or duplication.
- Flush in TWO state with In_Valid=1 (PC 0x18) -> next cycle Occupancy=0, Out_Valid=0, Out_Instr=0, In_Ready=1; 0x18 is never output.
- LANES=4, In_LaneMask=4'b0101 with all lanes 0xFFFFFFFF -> Out_Instr lanes 1 and 3 are 0, lanes 0 and 2 are 0xFFFFFFFF, Out_LaneMask=4'b0101.
- Simultaneous Rst_n=0 and Flush=1 during in_fire -> reset values next cycle. Randomised Out_Ready against a scoreboard -> in-order, lossless delivery.
